addsub_serial: RTL and testbench
================================

# addsub_serial

Multi-cycle, digit-serial unsigned add/subtract unit producing a sign-magnitude result, the parametrised successor to the team's 8-bit combinational subtractor. It processes `DIGIT` bits per clock over `WIDTH`-bit operands, so area can be traded against latency. It supports add and subtract modes and uses a start/done handshake. It feeds the 7-segment display path, which consumes `{sign, magnitude}`.

## Interface
- `WIDTH`, 8: operand width in bits (unsigned, no sign bit); must be a multiple of `DIGIT`.
- `DIGIT`, 1: bits processed per cycle; `N = WIDTH/DIGIT` digit steps.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when `ready`=1.
- `op` in 1: 0 = add (A+B), 1 = subtract (A−B); sampled with `start`.
- `a` in WIDTH: unsigned operand A; sampled with `start`.
- `b` in WIDTH: unsigned operand B; sampled with `start`.
- `abort` in 1: cancel the current operation (functional only with `ADDSUB_ABORT_EN`).
- `ready` out 1: high in IDLE; a new `start` is accepted.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle onward.
- `result` out WIDTH+2: `{sign, mag[WIDTH:0]}`; MSB is the sign (1 = negative).

## Operation
- **Reset values:** state IDLE, `ready`=1, `done`=0, `result`=0, internal operand/carry registers 0.
- **States:** IDLE → CALC → (NEG) → IDLE.
- **IDLE:** on `start`=1, latch `a`, `b`, `op`; set carry-in = `op`; move to CALC; drop `ready`.
- **CALC:** each cycle adds digit i of A and digit i of (op ? ~B : B) plus the registered carry, shifting the sum digit into the result shift register, LSB digit first. This takes `N` cycles.
- **End of CALC, add:** `mag = {carry_out, sum}` (WIDTH+1 bits), `sign`=0. Load `result`, pulse `done`, go to IDLE.
- **End of CALC, subtract, carry_out=1 (A≥B):** `sign`=0, `mag = {0, sum}`. Load `result`, pulse `done`, go to IDLE.
- **End of CALC, subtract, carry_out=0 (A<B):** go to NEG. NEG runs `N` cycles of serial two's-complement (~sum + 1, digit-serial carry).
- **End of NEG:** `sign`=1, `mag = {0, negated}`. Load `result`, pulse `done`, go to IDLE.
- **A==B in subtract:** yields `sign`=0, `mag`=0. Negative zero is never produced.
- **Result hold:** `result` changes only at a `done`; it holds its value between operations.
- **Busy:** `start` while `ready`=0 is ignored. It is not queued, and the operands are not re-sampled.
- **Reset mid-operation:** returns immediately to reset values; no `done` is issued.

## Timing
- **start at edge 0:**
  - Add, or subtract with A≥B: `done` high in the cycle after edge N, i.e. latency N cycles.
  - Subtract with A<B: latency 2N cycles.
- `ready` is low from edge 0 until the edge that asserts `done`, and is high in the `done` cycle. Back-to-back issue is therefore possible: `start` in the `done` cycle is accepted.
- `done` is exactly one cycle wide; `result` is registered and glitch-free.
- **Carry chain:** one DIGIT-bit adder per cycle; no combinational path from inputs to outputs.

## Configuration
- Macro: `ADDSUB_ABORT_EN`.
- **Defined:**
  - `abort`=1 in CALC or NEG returns to IDLE on the next edge, with no `done` and `result` unchanged.
  - `abort` and `start` together in IDLE: abort wins and nothing starts.
  - `abort` in IDLE has no effect.
- **Undefined:** the `abort` port exists but is ignored, and operations always run to completion.

## Test plan
- WIDTH=8, DIGIT=1: sub 200−55 → `result`=0x091 (sign 0, mag 145), `done` 8 cycles after start.
- WIDTH=8, DIGIT=1: sub 55−200 → sign 1, mag 145 (`result`=0x291), `done` 16 cycles after start. Also sub 77−77 → `result`=0x000.
- WIDTH=8, DIGIT=1: add 255+255 → `result`=0x1FE (mag 510, sign 0), latency 8. A second `start` issued in the `done` cycle is accepted.
- WIDTH=16, DIGIT=4: sub 0x1234−0xFFFF → sign 1, mag 0x0EDCB, latency 8. Add 0xFFFF+0x0001 → mag 0x10000, latency 4.
- `start` pulsed with new operands while busy → ignored, and the first result is unchanged. Assert `rst` mid-CALC → `ready`=1, `result`=0, no `done`.
- With `ADDSUB_ABORT_EN`: `abort` in cycle 3 of CALC → IDLE next cycle, no `done`, prior `result` held. Without the macro → the operation completes normally.

Source files
------------

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial unsigned add/subtract with sign-magnitude result.
//
// Processes DIGIT bits per clock over WIDTH-bit operands (N = WIDTH/DIGIT steps).
// Add and non-negative subtract take N cycles. A negative subtract takes another
// N cycles to serially two's-complement the raw difference into a magnitude.
//
// Optional feature macro: ADDSUB_ABORT_EN. When defined, abort cancels a running
// operation. When undefined, abort is ignored.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled only while ready=1
//   op     - 0 = a+b, 1 = a-b (sampled with start)
//   a, b   - unsigned WIDTH-bit operands (sampled with start)
//   abort  - cancel current operation (only with ADDSUB_ABORT_EN)
//   ready  - idle, a new start is accepted
//   done   - one-cycle completion pulse
//   result - {sign, mag[WIDTH:0]}, updated only at done
module addsub_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             ready,
    output logic             done,
    output logic [WIDTH+1:0] result
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = DIGIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NEG  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             op_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] opnd_a;
    logic [DIGIT-1:0] opnd_b;
    logic [DW-1:0]    dsum;
    logic [WIDTH-1:0] sum_next;
    logic             last;
    logic             abort_c;

`ifdef ADDSUB_ABORT_EN
    assign abort_c = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_c      = 1'b0;
`endif

    // Single DIGIT-bit adder shared by CALC (a + b/~b) and NEG (~diff + 0 + carry).
    always_comb begin
        opnd_a = a_sh[DIGIT-1:0];
        opnd_b = op_r ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];
        if (state == NEG) begin
            opnd_a = ~a_sh[DIGIT-1:0];
            opnd_b = '0;
        end
        dsum     = DW'(opnd_a) + DW'(opnd_b) + DW'(carry);
        // New digit enters at the top so the LSB digit ends up at bit 0 after N steps.
        sum_next = (sum_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last     = (cnt == CW'(N - 1));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            op_r   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Abort takes priority over a simultaneous start.
                    if (start && !abort_c) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        op_r   <= op;
                        carry  <= op;
                        sum_sh <= '0;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (abort_c) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        a_sh   <= a_sh >> DIGIT;
                        b_sh   <= b_sh >> DIGIT;
                        sum_sh <= sum_next;
                        carry  <= dsum[DIGIT];
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            cnt <= '0;
                            if (!op_r) begin
                                result <= {1'b0, dsum[DIGIT], sum_next};
                                done   <= 1'b1;
                                ready  <= 1'b1;
                                state  <= IDLE;
                            end else if (dsum[DIGIT]) begin
                                // No borrow: a >= b, difference is already the magnitude.
                                result <= {2'b00, sum_next};
                                done   <= 1'b1;
                                ready  <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                // Borrow: negate the raw difference serially.
                                a_sh   <= sum_next;
                                sum_sh <= '0;
                                carry  <= 1'b1;
                                state  <= NEG;
                            end
                        end
                    end
                end
                NEG: begin
                    if (abort_c) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        a_sh   <= a_sh >> DIGIT;
                        sum_sh <= sum_next;
                        carry  <= dsum[DIGIT];
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            cnt    <= '0;
                            result <= {2'b10, sum_next};
                            done   <= 1'b1;
                            ready  <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboard bench for addsub_serial.
// Two instances: WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4. The driver pushes the
// hand-computed result and latency of each accepted request; a monitor pops
// and compares on every done pulse.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, op8, abort8, ready8, done8;
    logic [7:0]  a8, b8;
    logic [9:0]  result8;

    logic        start16, op16, abort16, ready16, done16;
    logic [15:0] a16, b16;
    logic [17:0] result16;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [17:0] res;
        int unsigned start;
        int unsigned lat;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .abort(abort8), .ready(ready8), .done(done8), .result(result8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .abort(abort16), .ready(ready16), .done(done16), .result(result16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pop and compare on each done pulse.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) flag("u8 unexpected done");
            else begin
                e8 = q8.pop_front();
                check("u8 result", 32'(result8), 32'(e8.res));
                check("u8 latency", cyc - e8.start, e8.lat);
                check("u8 ready at done", 32'(ready8), 32'd1);
            end
        end
        if (!rst && done16) begin
            if (q16.size() == 0) flag("u16 unexpected done");
            else begin
                e16 = q16.pop_front();
                check("u16 result", 32'(result16), 32'(e16.res));
                check("u16 latency", cyc - e16.start, e16.lat);
                check("u16 ready at done", 32'(ready16), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go8(input logic o, input logic [7:0] x, input logic [7:0] y,
                       input logic [17:0] r, input int unsigned lat, input bit expect_done);
        int n = 0;
        while (!ready8 && n < 200) begin tick(); n++; end
        if (!ready8) flag("u8 ready timeout");
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        if (expect_done) q8.push_back('{res: r, start: cyc, lat: lat});
    endtask

    task automatic go16(input logic o, input logic [15:0] x, input logic [15:0] y,
                        input logic [17:0] r, input int unsigned lat);
        int n = 0;
        while (!ready16 && n < 200) begin tick(); n++; end
        if (!ready16) flag("u16 ready timeout");
        op16 = o; a16 = x; b16 = y; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        q16.push_back('{res: r, start: cyc, lat: lat});
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin tick(); n++; end
        if (q8.size() != 0) begin
            flag("u8 done timeout");
            q8.delete();
        end
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 100) begin tick(); n++; end
        if (q16.size() != 0) begin
            flag("u16 done timeout");
            q16.delete();
        end
    endtask

    task automatic wait_done8();
        int n = 0;
        do begin tick(); n++; end while (!done8 && n < 100);
        if (!done8) flag("u8 wait done timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; abort8 = 1'b0;
        start16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0; abort16 = 1'b0;
        tick();
        tick();
        check("reset ready8", 32'(ready8), 32'd1);
        check("reset done8", 32'(done8), 32'd0);
        check("reset result8", 32'(result8), 32'd0);
        check("reset ready16", 32'(ready16), 32'd1);
        check("reset result16", 32'(result16), 32'd0);
        rst = 1'b0;
        tick();

        // 8-bit subtract cases.
        go8(1'b1, 8'd200, 8'd55, 18'h091, 8, 1'b1);
        drain8();
        go8(1'b1, 8'd55, 8'd200, 18'h291, 16, 1'b1);
        drain8();
        go8(1'b1, 8'd77, 8'd77, 18'h000, 8, 1'b1);
        drain8();

        // Max add, then back-to-back start issued in the done cycle.
        go8(1'b0, 8'd255, 8'd255, 18'h1FE, 8, 1'b1);
        wait_done8();
        check("u8 ready in done cycle", 32'(ready8), 32'd1);
        go8(1'b0, 8'd1, 8'd2, 18'h003, 8, 1'b1);
        drain8();

        // 16-bit, 4-bit digits.
        go16(1'b1, 16'h1234, 16'hFFFF, 18'h2EDCB, 8);
        drain16();
        go16(1'b0, 16'hFFFF, 16'h0001, 18'h10000, 4);
        drain16();
        go16(1'b1, 16'h0000, 16'h0000, 18'h00000, 4);
        drain16();

        // Start while busy is ignored.
        go8(1'b0, 8'd10, 8'd20, 18'h01E, 8, 1'b1);
        tick();
        tick();
        op8 = 1'b1; a8 = 8'd5; b8 = 8'd100; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("u8 busy ready", 32'(ready8), 32'd0);
        drain8();
        repeat (20) tick();
        check("u8 result hold", 32'(result8), 32'h01E);

        // Abort asserted for CALC cycle 3 (sampled at third edge after accept).
`ifdef ADDSUB_ABORT_EN
        go8(1'b1, 8'd30, 8'd100, 18'h246, 16, 1'b0);
`else
        go8(1'b1, 8'd30, 8'd100, 18'h246, 16, 1'b1);
`endif
        tick();
        tick();
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
`ifdef ADDSUB_ABORT_EN
        check("u8 abort idle", 32'(ready8), 32'd1);
        repeat (20) tick();
        check("u8 abort result held", 32'(result8), 32'h01E);
`else
        check("u8 abort ignored busy", 32'(ready8), 32'd0);
        drain8();
        check("u8 abort ignored result", 32'(result8), 32'h246);
`endif

        // Reset in the middle of CALC.
        go8(1'b0, 8'd3, 8'd4, 18'h007, 8, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid reset ready8", 32'(ready8), 32'd1);
        check("mid reset result8", 32'(result8), 32'd0);
        check("mid reset done8", 32'(done8), 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("post reset result8", 32'(result8), 32'd0);
        check("post reset ready8", 32'(ready8), 32'd1);
        check("u8 queue empty", 32'(q8.size()), 32'd0);
        check("u16 queue empty", 32'(q16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
